// File: rtl/matrix_storage_bank_if.sv
// Storage-protocol bundle between the storage mux (master) and the matrix storage bank (slave).
interface matrix_storage_bank_if #(
    parameter int DW = 32,
    parameter int AW = 8
);
    logic [AW-1:0] i_rd_addr;
    logic [DW-1:0] o_rd_data;
    logic          i_we;
    logic [AW-1:0] i_waddr;
    logic [DW-1:0] i_wdata;
    logic          i_clr_start;
    logic          o_clr_busy;
    logic          o_clr_done;
    logic          o_wr_err;
    logic [7:0]    o_err_cnt;

    modport master (
        output i_rd_addr, i_we, i_waddr, i_wdata, i_clr_start,
        input  o_rd_data, o_clr_busy, o_clr_done, o_wr_err, o_err_cnt
    );

    modport slave (
        input  i_rd_addr, i_we, i_waddr, i_wdata, i_clr_start,
        output o_rd_data, o_clr_busy, o_clr_done, o_wr_err, o_err_cnt
    );
endinterface

// File: rtl/matrix_storage_bank.sv
// Shared matrix-element store: 1-cycle read with write-first bypass, one write port,
// background clear engine, and rejected-write error pulse/counter.
module matrix_storage_bank #(
    parameter int DEPTH = 200,
    parameter int DW    = 32,
    parameter int AW    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    matrix_storage_bank_if.slave   bus
);
    typedef enum logic [1:0] {CLEAR, DONE, READY} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   LIM  = (AW + 1)'(DEPTH);

    state_t        state, state_nxt;
    logic [AW-1:0] clr_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data;
    logic          wr_err;
    logic [7:0]    err_cnt;
    logic          clearing, waddr_in, raddr_in, wr_ok, wr_rej;
    logic          clr_busy, clr_done;

    assign clearing = (state == CLEAR);
    assign waddr_in = ({1'b0, bus.i_waddr} < LIM);
    assign raddr_in = ({1'b0, bus.i_rd_addr} < LIM);
    assign wr_ok    = bus.i_we && !clearing && waddr_in;
    assign wr_rej   = bus.i_we && !wr_ok;

    // Array has no reset; the clear engine is the only thing that initialises it.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[bus.i_waddr] <= bus.i_wdata;
        else if (clearing)
            mem[clr_ptr] <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= CLEAR;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_ptr == LAST) state_nxt = DONE;
            DONE:    state_nxt = READY;
            READY:   if (bus.i_clr_start) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        clr_busy = 1'b0;
        clr_done = 1'b0;
        case (state)
            CLEAR:   clr_busy = 1'b1;
            DONE:    clr_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ptr <= '0;
            rd_data <= '0;
            wr_err  <= 1'b0;
            err_cnt <= '0;
        end else begin
            // Pointer parks at the last address so it can never run past DEPTH.
            if (clearing && clr_ptr != LAST)
                clr_ptr <= clr_ptr + 1'b1;
            else if (state == READY && bus.i_clr_start)
                clr_ptr <= '0;

            wr_err <= wr_rej;
            if (wr_rej && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;

            if (!raddr_in)
                rd_data <= '0;
            else if (wr_ok && bus.i_waddr == bus.i_rd_addr)
                rd_data <= bus.i_wdata;
            else if (clearing && clr_ptr == bus.i_rd_addr)
                rd_data <= '0;
            else
                rd_data <= mem[bus.i_rd_addr];
        end
    end

    assign bus.o_rd_data  = rd_data;
    assign bus.o_clr_busy = clr_busy;
    assign bus.o_clr_done = clr_done;
    assign bus.o_wr_err   = wr_err;
    assign bus.o_err_cnt  = err_cnt;
endmodule

// File: tb/tb_matrix_storage_bank.sv
// Scoreboard bench for matrix_storage_bank: a per-cycle reference model queues expected
// outputs at stimulus time; a monitor pops and compares one entry after every edge.
module tb_matrix_storage_bank;
    localparam int DEPTH = 200;
    localparam int DW    = 32;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_storage_bank_if #(.DW(DW), .AW(AW)) bus();
    matrix_storage_bank #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        bit            rd_chk;
        logic [DW-1:0] rd;
        bit            err;
        logic [7:0]    cnt;
        bit            busy;
        bit            done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: contents, which words are known, clear work remaining, done phase.
    logic [DW-1:0] mmem [DEPTH];
    bit            known [DEPTH];
    int            clr_left;
    bit            done_ph;
    int            cnt;

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.rd_chk) cmp("rd_data", bus.o_rd_data, e.rd);
            cmp("wr_err",   DW'(bus.o_wr_err),   DW'(e.err));
            cmp("err_cnt",  DW'(bus.o_err_cnt),  DW'(e.cnt));
            cmp("clr_busy", DW'(bus.o_clr_busy), DW'(e.busy));
            cmp("clr_done", DW'(bus.o_clr_done), DW'(e.done));
        end
    end

    // Called at a negedge: drive one cycle, predict its outcome, advance to next negedge.
    task automatic step(input logic we, input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                        input logic [AW-1:0] raddr, input logic cs);
        exp_t e;
        bit   clearing, acc, rej;
        int   p, wa, ra;
        bus.i_we = we; bus.i_waddr = waddr; bus.i_wdata = wdata;
        bus.i_rd_addr = raddr; bus.i_clr_start = cs;
        wa = int'(waddr); ra = int'(raddr);
        clearing = (clr_left > 0);
        p = DEPTH - clr_left;
        acc = we && !clearing && wa < DEPTH;
        rej = we && !acc;
        e.rd_chk = 1'b1;
        e.rd = '0;
        if (ra >= DEPTH) e.rd = '0;
        else if (acc && wa == ra) e.rd = wdata;
        else if (clearing && p == ra) e.rd = '0;
        else begin
            e.rd_chk = known[ra];
            e.rd = mmem[ra];
        end
        if (rej && cnt < 255) cnt++;
        e.err = rej;
        e.cnt = 8'(cnt);
        if (acc) begin mmem[wa] = wdata; known[wa] = 1'b1; end
        if (clearing) begin mmem[p] = '0; known[p] = 1'b1; end
        if (clearing) begin
            clr_left--;
            done_ph = (clr_left == 0);
        end else if (done_ph) done_ph = 1'b0;
        else if (cs) clr_left = DEPTH;
        e.busy = (clr_left > 0);
        e.done = done_ph;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic [AW-1:0] raddr);
        step(1'b0, '0, '0, raddr, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        clr_left = DEPTH; done_ph = 1'b0; cnt = 0;
        bus.i_we = 1'b0; bus.i_clr_start = 1'b0;
        repeat (n) @(negedge clk);
        cmp("rst_busy",   DW'(bus.o_clr_busy), DW'(1));
        cmp("rst_done",   DW'(bus.o_clr_done), DW'(0));
        cmp("rst_wr_err", DW'(bus.o_wr_err),   DW'(0));
        cmp("rst_err_cnt", DW'(bus.o_err_cnt), DW'(0));
        cmp("rst_rd_data", bus.o_rd_data, '0);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int  cyc;
        bit  seen;
        cyc = 1;
        seen = 1'b0;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            idle('0);
            cyc++;
            if (bus.o_clr_done) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL %s: clr_done not seen within %0d cycles", name, 3 * DEPTH);
        end else begin
            cmp(name, DW'(cyc), DW'(DEPTH + 1));
        end
    endtask

    initial begin
        logic [AW-1:0] wa, ra;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        bus.i_rd_addr = '0; bus.i_we = 1'b0; bus.i_waddr = '0;
        bus.i_wdata = '0; bus.i_clr_start = 1'b0;
        @(negedge clk);

        // Power-up clear, then everything reads zero
        do_reset(3);
        wait_done("init_clear_cycles");
        for (int a = 0; a < DEPTH; a++) idle(AW'(a));

        // Plain write then read; neighbour untouched
        step(1'b1, 8'd5, 32'hDEADBEEF, 8'd0, 1'b0);
        idle(8'd5);
        idle(8'd6);

        // Same-edge write/read bypass
        step(1'b1, 8'd9, 32'h12345678, 8'd9, 1'b0);
        idle(8'd9);

        // Out-of-range writes, counter saturation
        step(1'b1, 8'd200, 32'hAAAA5555, 8'd200, 1'b0);
        idle(8'd200);
        for (int i = 0; i < 300; i++)
            step(1'b1, AW'($urandom_range(DEPTH, 255)), $urandom, AW'($urandom_range(0, 255)), 1'b0);
        idle(8'd5);
        cmp("err_cnt_saturated", DW'(bus.o_err_cnt), DW'(255));

        // Write during clear is dropped; clear wipes earlier data
        step(1'b0, '0, '0, 8'd5, 1'b1);
        step(1'b1, 8'd3, 32'hCAFEF00D, 8'd3, 1'b0);
        for (int k = 0; k < 3 * DEPTH && !bus.o_clr_done; k++) idle('0);
        idle(8'd3);
        idle(8'd5);
        cmp("addr5_cleared", bus.o_rd_data, '0);

        // Randomized traffic with occasional clears and write+clear collisions
        for (int i = 0; i < 3000; i++) begin
            wa = ($urandom_range(0, 9) < 8) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 255));
            ra = ($urandom_range(0, 3) == 0) ? wa :
                 (($urandom_range(0, 9) < 9) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 255)));
            step(1'($urandom_range(0, 1)), wa, $urandom, ra, 1'($urandom_range(0, 299) == 0));
        end

        // Reset in the middle of a clear restarts it from the beginning
        while (clr_left > 0 || done_ph) idle('0);
        step(1'b0, '0, '0, '0, 1'b1);
        while (clr_left > DEPTH - 100) idle('0);
        do_reset(2);
        wait_done("restart_clear_cycles");
        for (int i = 0; i < 40; i++) idle(AW'($urandom_range(0, DEPTH - 1)));

        @(negedge clk);
        @(negedge clk);
        cmp("scoreboard_drained", DW'(sb.size()), DW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
